// File: rtl/mmio_bridge_if.sv
// ---------------------------------------------------------------------------
// mmio_bridge_if
//   Core-side data bus between the RISC-V data port and mmio_bridge.
//   Signals:
//     enabler_write  core store strobe
//     address        core byte address (word-aligned)
//     data_write     core store data
//     data_read      load data returned to the core (combinational)
//   Modports:
//     master  core side (drives strobe/address/data, receives read data)
//     slave   bridge side
// ---------------------------------------------------------------------------
interface mmio_bridge_if;
  logic        enabler_write;
  logic [31:0] address;
  logic [31:0] data_write;
  logic [31:0] data_read;

  modport master (
    output enabler_write,
    output address,
    output data_write,
    input  data_read
  );

  modport slave (
    input  enabler_write,
    input  address,
    input  data_write,
    output data_read
  );
endinterface

// File: rtl/mmio_bridge.sv
// ---------------------------------------------------------------------------
// mmio_bridge
//   Sits between the core data port and dmem. Addresses whose bits [31:8]
//   equal MMIO_PAGE are decoded to board I/O; everything else goes to dmem.
//   Register map (offset = address[7:0]):
//     00 LED   RW    bits[9:0]
//     04 SW    RO    synchronised switches
//     08 KEY   RO    debounced key level, 1 = pressed
//     0C KEVT  RW1C  sticky press flags [2:0]
//     10 TMR   RW    free-running cycle counter      (timer build only)
//     14 TCMP  RW    compare value                  (timer build only)
//     18 TSTAT RW1C  bit0 = TMR matched TCMP        (timer build only)
//   Build option: define R2RV_MMIO_TIMER_EN to implement TMR/TCMP/TSTAT.
//   Without it there are no timer flops and offsets 10/14/18 read 0.
// Ports:
//   clk       system clock, all state on posedge
//   reset     asynchronous active-low reset
//   bus       core data bus (slave modport)
//   dmem_we   write enable to dmem, suppressed for MMIO accesses
//   dmem_rd   dmem read data, passed through for non-MMIO loads
//   sw        raw slide switches (asynchronous)
//   key       raw pushbuttons, active-low, asynchronous, bouncing
//   led       LED register output
// ---------------------------------------------------------------------------
module mmio_bridge #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic [23:0] MMIO_PAGE       = 24'hFFFFFF
) (
  input  logic         clk,
  input  logic         reset,
  mmio_bridge_if.slave bus,
  output logic         dmem_we,
  input  logic [31:0]  dmem_rd,
  input  logic [9:0]   sw,
  input  logic [2:0]   key,
  output logic [9:0]   led
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [7:0] OFF_LED   = 8'h00;
  localparam logic [7:0] OFF_SW    = 8'h04;
  localparam logic [7:0] OFF_KEY   = 8'h08;
  localparam logic [7:0] OFF_KEVT  = 8'h0C;
  localparam logic [7:0] OFF_TMR   = 8'h10;
  localparam logic [7:0] OFF_TCMP  = 8'h14;
  localparam logic [7:0] OFF_TSTAT = 8'h18;

  logic             mmio_sel_s;
  logic [7:0]       offset_s;
  logic             wr_s;
  logic [31:0]      rd_mmio_s;

  logic [9:0]       sw_s1_q, sw_s2_q;
  logic [2:0]       key_s1_q, key_s2_q;
  logic [2:0]       key_sync_s;
  logic [2:0]       stable_q, stable_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       press_s;

  logic [9:0]       led_q, led_d;
  logic [2:0]       kevt_q, kevt_d;

  logic [31:0]      tmr_rd_s;
  logic [31:0]      tcmp_rd_s;
  logic             tstat_rd_s;

  // Address decode and dmem write gating
  always_comb begin
    mmio_sel_s = (bus.address[31:8] == MMIO_PAGE);
    offset_s   = bus.address[7:0];
    wr_s       = bus.enabler_write & mmio_sel_s;
    dmem_we    = bus.enabler_write & ~mmio_sel_s;
  end

  // Two-flop synchronisers; key flops idle at 1 (released, active-low input)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1_q  <= 10'h000;
      sw_s2_q  <= 10'h000;
      key_s1_q <= 3'b111;
      key_s2_q <= 3'b111;
    end else begin
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      key_s1_q <= key;
      key_s2_q <= key_s1_q;
    end
  end

  // Debounce next-state: a level is accepted only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any return to the stable value
  // restarts the count, so the counter never reaches past CNT_LAST.
  always_comb begin
    key_sync_s = ~key_s2_q;
    stable_d   = stable_q;
    cnt_d      = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (key_sync_s[i] == stable_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = key_sync_s[i];
        cnt_d[i]    = {CNT_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1'b1);
      end
    end
    press_s = stable_d & ~stable_q;
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q <= 3'b000;
      cnt_q    <= {3{ {CNT_W{1'b0}} }};
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // LED and KEVT next-state; a press in the same cycle as a W1C keeps the flag
  always_comb begin
    if (wr_s && (offset_s == OFF_LED)) begin
      led_d = bus.data_write[9:0];
    end else begin
      led_d = led_q;
    end
    if (wr_s && (offset_s == OFF_KEVT)) begin
      kevt_d = (kevt_q & ~bus.data_write[2:0]) | press_s;
    end else begin
      kevt_d = kevt_q | press_s;
    end
  end

  // LED and KEVT registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q  <= 10'h000;
      kevt_q <= 3'b000;
    end else begin
      led_q  <= led_d;
      kevt_q <= kevt_d;
    end
  end

`ifdef R2RV_MMIO_TIMER_EN
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic        tstat_q, tstat_d;

  // Timer next-state: a TMR write replaces this cycle's increment; match
  // detection uses the pre-edge values so TSTAT rises the cycle after equality.
  always_comb begin
    if (wr_s && (offset_s == OFF_TMR)) begin
      tmr_d = bus.data_write;
    end else begin
      tmr_d = tmr_q + 32'd1;
    end
    if (wr_s && (offset_s == OFF_TCMP)) begin
      tcmp_d = bus.data_write;
    end else begin
      tcmp_d = tcmp_q;
    end
    if (wr_s && (offset_s == OFF_TSTAT)) begin
      tstat_d = (tstat_q & ~bus.data_write[0]) | (tmr_q == tcmp_q);
    end else begin
      tstat_d = tstat_q | (tmr_q == tcmp_q);
    end
  end

  // Timer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_q   <= 32'h0000_0000;
      tcmp_q  <= 32'hFFFF_FFFF;
      tstat_q <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      tcmp_q  <= tcmp_d;
      tstat_q <= tstat_d;
    end
  end

  assign tmr_rd_s   = tmr_q;
  assign tcmp_rd_s  = tcmp_q;
  assign tstat_rd_s = tstat_q;
`else
  // Timer absent: offsets read 0; upper store-data bits have no destination.
  logic unused_wdata_s;
  assign unused_wdata_s = ^bus.data_write[31:10];
  assign tmr_rd_s   = 32'h0000_0000;
  assign tcmp_rd_s  = 32'h0000_0000;
  assign tstat_rd_s = 1'b0;
`endif

  // Combinational read mux; unmapped offsets return 0
  always_comb begin
    rd_mmio_s = 32'h0000_0000;
    case (offset_s)
      OFF_LED:   rd_mmio_s = {22'h000000, led_q};
      OFF_SW:    rd_mmio_s = {22'h000000, sw_s2_q};
      OFF_KEY:   rd_mmio_s = {29'h00000000, stable_q};
      OFF_KEVT:  rd_mmio_s = {29'h00000000, kevt_q};
      OFF_TMR:   rd_mmio_s = tmr_rd_s;
      OFF_TCMP:  rd_mmio_s = tcmp_rd_s;
      OFF_TSTAT: rd_mmio_s = {31'h00000000, tstat_rd_s};
      default:   rd_mmio_s = 32'h0000_0000;
    endcase
    if (mmio_sel_s) begin
      bus.data_read = rd_mmio_s;
    end else begin
      bus.data_read = dmem_rd;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// ---------------------------------------------------------------------------
// tb_mmio_bridge
//   Self-checking bench for mmio_bridge with DEBOUNCE_CYCLES = 8. A cycle
//   model of the register map (key acceptance expressed as "the last 8
//   synchronised samples all disagree with the accepted level") predicts
//   data_read, dmem_we and led, which are compared on every falling edge.
//   Directed sequences pin the model with hand-computed values; a random
//   phase exercises bus traffic, switch changes and key bouncing.
// ---------------------------------------------------------------------------
module tb_mmio_bridge;
  localparam int          DB   = 8;
  localparam logic [23:0] PAGE = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dmem_we;
  logic [31:0] dmem_rd;
  logic [9:0]  sw;
  logic [2:0]  key;
  logic [9:0]  led;

  int n_pass  = 0;
  int n_total = 0;

  mmio_bridge_if bus_if ();

  mmio_bridge #(.DEBOUNCE_CYCLES(DB), .MMIO_PAGE(PAGE)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .dmem_we (dmem_we),
    .dmem_rd (dmem_rd),
    .sw      (sw),
    .key     (key),
    .led     (led)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [9:0]    m_led;
  logic [9:0]    m_sw_h0, m_sw_h1;
  logic [2:0]    m_k_h0, m_k_h1;
  logic [DB-1:0] m_win [3];
  logic [2:0]    m_stable, m_kevt;
  logic [31:0]   m_tmr, m_tcmp;
  logic          m_tstat;

  task automatic model_reset();
    m_led = 10'h0; m_sw_h0 = 10'h0; m_sw_h1 = 10'h0;
    m_k_h0 = 3'b111; m_k_h1 = 3'b111;
    for (int i = 0; i < 3; i++) m_win[i] = '0;
    m_stable = 3'b000; m_kevt = 3'b000;
    m_tmr = 32'h0; m_tcmp = 32'hFFFF_FFFF; m_tstat = 1'b0;
  endtask

  task automatic model_step();
    logic        wr;
    logic [7:0]  off;
    logic [2:0]  sync, nstab, clr;
    logic        hit;
    wr    = bus_if.enabler_write && (bus_if.address[31:8] == PAGE);
    off   = bus_if.address[7:0];
    sync  = ~m_k_h1;
    nstab = m_stable;
    for (int i = 0; i < 3; i++) begin
      m_win[i] = {m_win[i][DB-2:0], sync[i]};
      if (m_win[i] == {DB{~m_stable[i]}}) nstab[i] = ~m_stable[i];
    end
    clr    = (wr && off == 8'h0C) ? bus_if.data_write[2:0] : 3'b000;
    m_kevt = (m_kevt & ~clr) | (nstab & ~m_stable);
    m_stable = nstab;
    if (wr && off == 8'h00) m_led = bus_if.data_write[9:0];
`ifdef R2RV_MMIO_TIMER_EN
    hit     = (m_tmr == m_tcmp);
    m_tstat = (m_tstat & ~(wr && off == 8'h18 && bus_if.data_write[0])) | hit;
    m_tmr   = (wr && off == 8'h10) ? bus_if.data_write : m_tmr + 32'd1;
    if (wr && off == 8'h14) m_tcmp = bus_if.data_write;
`else
    hit = 1'b0;
`endif
    m_sw_h1 = m_sw_h0; m_sw_h0 = sw;
    m_k_h1  = m_k_h0;  m_k_h0  = key;
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [31:0] drd);
    if (a[31:8] != PAGE) return drd;
    case (a[7:0])
      8'h00: return {22'h0, m_led};
      8'h04: return {22'h0, m_sw_h1};
      8'h08: return {29'h0, m_stable};
      8'h0C: return {29'h0, m_kevt};
`ifdef R2RV_MMIO_TIMER_EN
      8'h10: return m_tmr;
      8'h14: return m_tcmp;
      8'h18: return {31'h0, m_tstat};
`endif
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, got, exp);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_rdata", bus_if.data_read, exp_read(bus_if.address, dmem_rd));
      chk("cmp_dmem_we", {31'h0, dmem_we},
          {31'h0, bus_if.enabler_write & (bus_if.address[31:8] != PAGE)});
      chk("cmp_led", {22'h0, led}, {22'h0, m_led});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    bus_if.enabler_write = we;
    bus_if.address       = a;
    bus_if.data_write    = d;
  endtask

  task automatic idle(input int n, input logic [7:0] off);
    for (int i = 0; i < n; i++) cyc(1'b0, {PAGE, off}, 32'h0);
  endtask

  task automatic rand_cycle();
    int unsigned r;
    logic [31:0] a, d;
    r = $urandom_range(0, 3);
    if (r < 2) a = {PAGE, 8'($urandom_range(0, 7) * 4)};
    else if (r == 2) a = {PAGE, 8'($urandom_range(8, 63) * 4)};
    else begin
      a = $urandom & 32'hFFFF_FFFC;
      if (a[31:8] == PAGE) a[31] = 1'b0;
    end
    d = $urandom;
    if (a[7:0] == 8'h14 && $urandom_range(0, 1) == 1) d = m_tmr + 32'($urandom_range(1, 20));
    cyc(1'($urandom_range(0, 1)), a, d);
    dmem_rd = $urandom;
    for (int i = 0; i < 3; i++) if ($urandom_range(0, 19) == 0) key[i] = ~key[i];
    if ($urandom_range(0, 7) == 0) sw = 10'($urandom);
  endtask

  initial begin
    bus_if.enabler_write = 1'b0;
    bus_if.address       = 32'h0;
    bus_if.data_write    = 32'h0;
    dmem_rd = 32'h0; sw = 10'h0; key = 3'b111;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;

    // reset state
    cyc(1'b0, {PAGE, 8'h00}, 32'h0); #1 chk("rst_led_rd", bus_if.data_read, 32'h0);
    cyc(1'b0, {PAGE, 8'h08}, 32'h0); #1 chk("rst_key", bus_if.data_read, 32'h0);
    cyc(1'b0, {PAGE, 8'h0C}, 32'h0); #1 chk("rst_kevt", bus_if.data_read, 32'h0);
    cyc(1'b0, {PAGE, 8'h14}, 32'h0);
`ifdef R2RV_MMIO_TIMER_EN
    #1 chk("rst_tcmp", bus_if.data_read, 32'hFFFF_FFFF);
`else
    #1 chk("rst_tcmp_off", bus_if.data_read, 32'h0);
`endif

    // switch synchroniser: visible two edges after the change
    cyc(1'b0, {PAGE, 8'h04}, 32'h0); sw = 10'h2A5;
    cyc(1'b0, {PAGE, 8'h04}, 32'h0); #1 chk("sw_lat1", bus_if.data_read, 32'h0);
    cyc(1'b0, {PAGE, 8'h04}, 32'h0); #1 chk("sw_lat2", bus_if.data_read, 32'h2A5);

    // LED store/load, no dmem write
    cyc(1'b1, 32'hFFFF_FF00, 32'h3FF); #1 chk("t1_we", {31'h0, dmem_we}, 32'h0);
    cyc(1'b0, 32'hFFFF_FF00, 32'h0);  #1 chk("t1_led", {22'h0, led}, 32'h3FF);
    chk("t1_rd", bus_if.data_read, 32'h3FF);

    // dmem pass-through
    dmem_rd = 32'h1234_5678;
    cyc(1'b1, 32'h0000_0040, 32'hABCD); #1 chk("t2_we", {31'h0, dmem_we}, 32'h1);
    cyc(1'b0, 32'h0000_0040, 32'h0);    #1 chk("t2_led", {22'h0, led}, 32'h3FF);
    chk("t2_rd", bus_if.data_read, 32'h1234_5678);

    // key[1] bouncing every 3 cycles, then held pressed
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 3; c++) begin
        cyc(1'b0, {PAGE, 8'h08}, 32'h0);
        key[1] = p[0];
        #1 chk("t3_bounce", bus_if.data_read, 32'h0);
      end
    end
    cyc(1'b0, {PAGE, 8'h08}, 32'h0); key = 3'b101;
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, {PAGE, 8'h08}, 32'h0);
      #1 chk("t3_hold", bus_if.data_read, (i >= 10) ? 32'h2 : 32'h0);
    end
    cyc(1'b0, {PAGE, 8'h0C}, 32'h0); #1 chk("t3_kevt", bus_if.data_read, 32'h2);

    // press all, release all: release edges add nothing
    key = 3'b000; idle(12, 8'h08);
    key = 3'b111; idle(12, 8'h08);
    #1 chk("t4_rel", bus_if.data_read, 32'h0);
    cyc(1'b0, {PAGE, 8'h0C}, 32'h0); #1 chk("t4_all", bus_if.data_read, 32'h7);
    cyc(1'b1, {PAGE, 8'h0C}, 32'h1);
    cyc(1'b0, {PAGE, 8'h0C}, 32'h0); #1 chk("t4_w1c", bus_if.data_read, 32'h6);
    // W1C of bit0 coinciding with a key[0] press edge
    cyc(1'b0, {PAGE, 8'h0C}, 32'h0); key = 3'b110;
    idle(8, 8'h0C);
    cyc(1'b1, {PAGE, 8'h0C}, 32'h1);
    cyc(1'b0, {PAGE, 8'h0C}, 32'h0); #1 chk("t4_setwins", bus_if.data_read, 32'h7);
    key = 3'b111;
    cyc(1'b1, {PAGE, 8'h0C}, 32'h7);

    // timer
`ifdef R2RV_MMIO_TIMER_EN
    cyc(1'b1, {PAGE, 8'h18}, 32'h1);
    cyc(1'b1, {PAGE, 8'h10}, 32'hFFFF_FFFE);
    cyc(1'b1, {PAGE, 8'h14}, 32'h0);
    cyc(1'b0, {PAGE, 8'h10}, 32'h0); #1 chk("t5_ff", bus_if.data_read, 32'hFFFF_FFFF);
    cyc(1'b0, {PAGE, 8'h10}, 32'h0); #1 chk("t5_wrap", bus_if.data_read, 32'h0);
    cyc(1'b0, {PAGE, 8'h18}, 32'h0); #1 chk("t5_tstat", bus_if.data_read, 32'h1);
    cyc(1'b0, {PAGE, 8'h14}, 32'h0); #1 chk("t5_tcmp", bus_if.data_read, 32'h0);
    cyc(1'b1, {PAGE, 8'h18}, 32'h1);
    cyc(1'b0, {PAGE, 8'h18}, 32'h0); #1 chk("t5_clr", bus_if.data_read, 32'h0);
`else
    cyc(1'b1, {PAGE, 8'h10}, 32'hDEAD_BEEF);
    cyc(1'b1, {PAGE, 8'h14}, 32'hDEAD_BEEF);
    cyc(1'b1, {PAGE, 8'h18}, 32'hFFFF_FFFF);
    cyc(1'b0, {PAGE, 8'h10}, 32'h0); #1 chk("t5_off_tmr", bus_if.data_read, 32'h0);
    cyc(1'b0, {PAGE, 8'h14}, 32'h0); #1 chk("t5_off_tcmp", bus_if.data_read, 32'h0);
    cyc(1'b0, {PAGE, 8'h18}, 32'h0); #1 chk("t5_off_tstat", bus_if.data_read, 32'h0);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) rand_cycle();

    // asynchronous reset in the middle of a debounce
    key = 3'b111; idle(12, 8'h08);
    key = 3'b000; idle(12, 8'h08);
    #1 chk("t6_key", bus_if.data_read, 32'h7);
    cyc(1'b1, {PAGE, 8'h00}, 32'h155);
    cyc(1'b0, {PAGE, 8'h0C}, 32'h0); key = 3'b111;
    idle(4, 8'h0C);
    #1 chk("t6_kevt_pre", bus_if.data_read, 32'h7);
    chk("t6_led_pre", {22'h0, led}, 32'h155);
    @(posedge clk); #1 reset = 1'b0;
    #1 chk("t6_led", {22'h0, led}, 32'h0);
    bus_if.address = {PAGE, 8'h08};
    #1 chk("t6_key_rst", bus_if.data_read, 32'h0);
    bus_if.address = {PAGE, 8'h0C};
    #1 chk("t6_kevt_rst", bus_if.data_read, 32'h0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    for (int n = 0; n < 200; n++) rand_cycle();

    @(posedge clk); #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
